// File: rtl/pos_to_lag.sv
// Inverse geometry for the 6+1 hexagonal mic array: target (x,y,z) mm -> per-mic lag in samples vs centre mic.
// Fixed latency: done 540 cycles after ena for in-range input, 2 cycles for out-of-range input.
module pos_to_lag #(
  parameter int L      = 200,
  parameter int VEL    = 340,
  parameter int FREQ   = 93750,
  parameter int MAX_MM = 10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic signed [31:0] x_position,
  input  logic signed [31:0] y_position,
  input  logic        [15:0] z_position,
  output logic signed [31:0] lag_diff [0:5],
  output logic               busy,
  output logic               range_err,
  output logic               done
);

  localparam int DEN = VEL * 10000;
  localparam logic signed [31:0] MAX_S = 32'(MAX_MM);
  localparam logic signed [31:0] MIC_Y = 32'sd173;

  typedef enum logic [3:0] {
    IDLE, LATCH, SQ_SUM, SQRT, NEXT_D, DIFF, DIV, NEXT_L, FINISH
  } state_t;

  state_t state_q, state_d;

  // Index 0 is the centre mic, indices 1..6 are mics 0..5 at 60 degree steps.
  function automatic logic signed [31:0] pos_x(input logic [2:0] j);
    case (j)
      3'd1:       return 32'(L);
      3'd2, 3'd6: return 32'(L / 2);
      3'd3, 3'd5: return -32'(L / 2);
      3'd4:       return -32'(L);
      default:    return '0;
    endcase
  endfunction

  function automatic logic signed [31:0] pos_y(input logic [2:0] j);
    case (j)
      3'd2, 3'd3: return MIC_Y;
      3'd5, 3'd6: return -MIC_Y;
      default:    return '0;
    endcase
  endfunction

  logic signed [31:0] xs_q, ys_q;
  logic        [31:0] zs_q;
  logic               bad_q, neg_q;
  logic        [2:0]  j_q, k_q;
  logic        [5:0]  cnt_q;
  logic        [63:0] rad_q;
  logic        [33:0] rem_q;
  logic        [31:0] root_q;
  logic        [31:0] dist_q [0:6];
  logic        [47:0] dvd_q;
  logic        [47:0] drem_q;

  logic signed [31:0] dx, dy, diff;
  logic signed [63:0] dx64, dy64;
  logic        [63:0] sum;
  logic        [35:0] sq_rem, sq_trial;
  logic               sq_ge;
  logic        [31:0] diff_abs;
  logic        [47:0] mag;
  logic        [48:0] dv_rem;
  logic               dv_ge;

  // Shared datapath: squared distance, one sqrt step, lag numerator, one divide step.
  always_comb begin
    dx       = xs_q - pos_x(j_q);
    dy       = ys_q - pos_y(j_q);
    dx64     = {{32{dx[31]}}, dx};
    dy64     = {{32{dy[31]}}, dy};
    sum      = $unsigned(dx64 * dx64) + $unsigned(dy64 * dy64) + ({32'd0, zs_q} * {32'd0, zs_q});
    sq_rem   = {rem_q, rad_q[63:62]};
    sq_trial = {2'b00, root_q, 2'b01};
    sq_ge    = (sq_rem >= sq_trial);
    diff     = $signed(dist_q[3'(k_q + 3'd1)]) - $signed(dist_q[0]);
    diff_abs = diff[31] ? 32'(-diff) : 32'(diff);
    mag      = 48'({32'd0, diff_abs} * 64'(FREQ) + 64'(DEN / 2));
    dv_rem   = {drem_q, dvd_q[47]};
    dv_ge    = (dv_rem >= 49'(DEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ena) state_d = LATCH;
      LATCH:   state_d = bad_q ? FINISH : SQ_SUM;
      SQ_SUM:  state_d = SQRT;
      SQRT:    if (cnt_q == 6'd31) state_d = NEXT_D;
      NEXT_D:  state_d = (j_q == 3'd6) ? DIFF : SQ_SUM;
      DIFF:    state_d = DIV;
      DIV:     if (cnt_q == 6'd47) state_d = NEXT_L;
      NEXT_L:  state_d = (k_q == 3'd5) ? FINISH : DIFF;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE) && (state_q != FINISH);
    done = (state_q == FINISH);
  end

  // The divider shifts the dividend out of dvd_q's top while quotient bits enter its bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q      <= '0;
      ys_q      <= '0;
      zs_q      <= '0;
      bad_q     <= 1'b0;
      neg_q     <= 1'b0;
      j_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      dvd_q     <= '0;
      drem_q    <= '0;
      range_err <= 1'b0;
      for (int i = 0; i < 7; i++) dist_q[i] <= '0;
      for (int i = 0; i < 6; i++) lag_diff[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (ena) begin
          xs_q  <= x_position * 32'sd10;
          ys_q  <= y_position * 32'sd10;
          zs_q  <= {16'd0, z_position} * 32'd10;
          bad_q <= (x_position > MAX_S) || (x_position < -MAX_S) ||
                   (y_position > MAX_S) || (y_position < -MAX_S) ||
                   ({16'd0, z_position} > 32'(MAX_MM));
        end
        LATCH: begin
          range_err <= bad_q;
          j_q       <= '0;
          k_q       <= '0;
          if (bad_q) for (int i = 0; i < 6; i++) lag_diff[i] <= '0;
        end
        SQ_SUM: begin
          rad_q  <= sum;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= '0;
        end
        SQRT: begin
          rad_q  <= {rad_q[61:0], 2'b00};
          rem_q  <= sq_ge ? 34'(sq_rem - sq_trial) : 34'(sq_rem);
          root_q <= {root_q[30:0], sq_ge};
          cnt_q  <= cnt_q + 6'd1;
        end
        NEXT_D: begin
          dist_q[j_q] <= root_q;
          j_q         <= j_q + 3'd1;
        end
        DIFF: begin
          dvd_q  <= mag;
          drem_q <= '0;
          neg_q  <= diff[31];
          cnt_q  <= '0;
        end
        DIV: begin
          drem_q <= dv_ge ? 48'(dv_rem - 49'(DEN)) : dv_rem[47:0];
          dvd_q  <= {dvd_q[46:0], dv_ge};
          cnt_q  <= cnt_q + 6'd1;
        end
        NEXT_L: begin
          lag_diff[k_q] <= neg_q ? -$signed(dvd_q[31:0]) : $signed(dvd_q[31:0]);
          k_q           <= k_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_to_lag.sv
// Bench for pos_to_lag: directed geometry cases, range limits, busy/reset behaviour, random vectors vs a real-valued model.
module tb_pos_to_lag;

  localparam int LATENCY     = 540;
  localparam int ERR_LATENCY = 2;
  localparam int TIMEOUT     = 1000;
  localparam int N_RANDOM    = 100;

  logic               clk;
  logic               rst_n;
  logic               ena;
  logic signed [31:0] x_position, y_position;
  logic        [15:0] z_position;
  logic signed [31:0] lag_diff [0:5];
  logic               busy, range_err, done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pos_to_lag dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x_position(x_position), .y_position(y_position), .z_position(z_position),
    .lag_diff(lag_diff), .busy(busy), .range_err(range_err), .done(done)
  );

  typedef struct packed {
    logic [5:0][31:0] lag;
    logic             err;
    logic             approx;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic checkEq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkNear(input string tag, input logic signed [31:0] obs, input int expv);
    total++;
    assert (!$isunknown(obs) && int'(obs) >= expv - 1 && int'(obs) <= expv + 1) else begin
      bad++;
      $error("[TB] FAIL %s: observed %0d expected %0d +/-1", tag, obs, expv);
    end
  endtask

  function automatic real micX(input int k);
    case (k)
      0: return 200.0;
      1: return 100.0;
      2: return -100.0;
      3: return -200.0;
      4: return -100.0;
      default: return 100.0;
    endcase
  endfunction

  function automatic real micY(input int k);
    case (k)
      1, 2: return 173.0;
      4, 5: return -173.0;
      default: return 0.0;
    endcase
  endfunction

  function automatic int roundAway(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic exp_t modelExp(input int x, input int y, input int z);
    exp_t r;
    real xs, ys, zs, d0, dk, ex, ey;
    r = '0;
    if (x > 10000 || x < -10000 || y > 10000 || y < -10000 || z > 10000) begin
      r.err = 1'b1;
      return r;
    end
    r.approx = 1'b1;
    xs = 10.0 * x;
    ys = 10.0 * y;
    zs = 10.0 * z;
    d0 = $sqrt(xs * xs + ys * ys + zs * zs);
    for (int k = 0; k < 6; k++) begin
      ex = xs - micX(k);
      ey = ys - micY(k);
      dk = $sqrt(ex * ex + ey * ey + zs * zs);
      r.lag[k] = 32'(roundAway((dk - d0) * 93750.0 / 3400000.0));
    end
    return r;
  endfunction

  function automatic exp_t mkExp(input int l0, input int l1, input int l2, input int l3, input int l4, input int l5);
    exp_t r;
    r = '0;
    r.lag[0] = 32'(l0);
    r.lag[1] = 32'(l1);
    r.lag[2] = 32'(l2);
    r.lag[3] = 32'(l3);
    r.lag[4] = 32'(l4);
    r.lag[5] = 32'(l5);
    return r;
  endfunction

  task automatic applyStimulus(input int x, input int y, input int z, input exp_t e);
    @(negedge clk);
    x_position = x;
    y_position = y;
    z_position = 16'(z);
    ena        = 1'b1;
    sb_q.push_back(e);
    exp_done++;
    @(negedge clk);
    ena = 1'b0;
    checkEq("busy_start", busy, 1);
  endtask

  task automatic checkOutput(input int start_cnt);
    int   cnt;
    exp_t e;
    cnt = start_cnt;
    while (done !== 1'b1 && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    assert (done === 1'b1) else begin
      bad++;
      $error("[TB] FAIL done_wait: observed done=%b after %0d cycles expected 1", done, cnt);
    end
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard: observed 0 entries expected at least 1");
    end
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    checkEq("range_err", range_err, e.err);
    checkEq("latency", cnt, e.err ? ERR_LATENCY : LATENCY);
    for (int i = 0; i < 6; i++) begin
      if (e.approx) checkNear($sformatf("lag%0d", i), lag_diff[i], int'($signed(e.lag[i])));
      else          checkEq($sformatf("lag%0d", i), lag_diff[i], e.lag[i]);
    end
    @(negedge clk);
    checkEq("done_pulse", done, 0);
    checkEq("busy_end", busy, 0);
  endtask

  initial begin
    int   done_before;
    int   rx, ry, rz;
    exp_t far_x;
    far_x      = mkExp(-6, -3, 3, 6, 3, -3);
    rst_n      = 1'b0;
    ena        = 1'b0;
    x_position = '0;
    y_position = '0;
    z_position = '0;
    repeat (3) @(negedge clk);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_done", done, 0);
    checkEq("rst_range_err", range_err, 0);
    for (int i = 0; i < 6; i++) checkEq($sformatf("rst_lag%0d", i), lag_diff[i], 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed geometry");
    applyStimulus(0, 0, 1000, mkExp(0, 0, 0, 0, 0, 0));
    checkOutput(1);
    applyStimulus(1000, 0, 0, far_x);
    checkOutput(1);
    applyStimulus(0, 1000, 0, mkExp(0, -5, -5, 0, 5, 5));
    checkOutput(1);

    $display("[TB] range limits");
    applyStimulus(20000, 0, 0, modelExp(20000, 0, 0));
    checkOutput(1);
    applyStimulus(10000, -10000, 10000, modelExp(10000, -10000, 10000));
    checkOutput(1);
    applyStimulus(-10001, 0, 0, modelExp(-10001, 0, 0));
    checkOutput(1);
    applyStimulus(0, 0, 10001, modelExp(0, 0, 10001));
    checkOutput(1);
    applyStimulus(-10000, 10000, 0, modelExp(-10000, 10000, 0));
    checkOutput(1);

    $display("[TB] ena while busy");
    applyStimulus(1000, 0, 0, far_x);
    repeat (9) @(negedge clk);
    x_position = 0;
    y_position = 1000;
    z_position = 0;
    ena        = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    checkOutput(11);

    $display("[TB] reset mid-sqrt");
    applyStimulus(0, 1000, 0, mkExp(0, -5, -5, 0, 5, 5));
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkEq("midrst_busy", busy, 0);
    checkEq("midrst_done", done, 0);
    checkEq("midrst_range_err", range_err, 0);
    for (int i = 0; i < 6; i++) checkEq($sformatf("midrst_lag%0d", i), lag_diff[i], 0);
    rst_n = 1'b1;
    sb_q.delete();
    exp_done--;
    done_before = done_cnt;
    repeat (600) @(negedge clk);
    checkEq("no_done_after_reset", done_cnt, done_before);
    applyStimulus(1000, 0, 0, far_x);
    checkOutput(1);

    $display("[TB] random vectors");
    for (int n = 0; n < N_RANDOM; n++) begin
      rx = int'($urandom_range(20000)) - 10000;
      ry = int'($urandom_range(20000)) - 10000;
      rz = int'($urandom_range(10000));
      applyStimulus(rx, ry, rz, modelExp(rx, ry, rz));
      checkOutput(1);
    end

    repeat (5) @(negedge clk);
    checkEq("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
